spike_class_arbiter: RTL
========================

Name: spike_class_arbiter

Overview:
Output-layer decision block for the SNN ECG classifier. It watches the N_OUT output-neuron spike lines over a bounded inference window and produces one class decision per inference. Two decision modes are supported: first-spike (earliest spiking neuron wins) and spike-count vote (class with the most spikes over the full window wins). A start/valid/ack handshake connects it to the inference controller; a timeout is flagged when no decision can be made.

Parameters:
N_OUT, 6, number of output neurons; neuron i belongs to class (i mod N_CLASS)
N_CLASS, 3, number of classes; code N_CLASS on class_out means "no decision"
DURATION, 300, inference window length in time steps (timer_en pulses); must be >= 1
MODE, 0, 0 = first-spike, 1 = spike-count vote
CNT_W, 8, width of the per-class spike counters (mode 1)
CLS_W, $clog2(N_CLASS+1), class_out width (derived)
TMR_W, $clog2(DURATION+1), step-counter width (derived)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
start  in  1  begin an inference; honoured only in IDLE
timer_en  in  1  one network time step; spikes_in is sampled only on these cycles
spikes_in  in  N_OUT  output-neuron spikes for the current step
result_ack  in  1  consumer accepts the result; honoured only in DONE
busy  out  1  high while in RUN
result_valid  out  1  high while in DONE
class_out  out  CLS_W  decided class; N_CLASS = none
timeout  out  1  window expired without a decision
steps_out  out  TMR_W  steps consumed, including the decision step

Behaviour:
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- Reset (resetn=0 at a clk edge): state IDLE; busy=0; result_valid=0; timeout=0; class_out=N_CLASS; steps_out=0; counters cleared. Reset has priority over every other input, including mid-RUN; an aborted inference produces no result.
- IDLE: when start=1, go to RUN. Load the step timer with DURATION, clear steps_out and the class counters. timer_en and spikes are ignored in IDLE.
- RUN: on each timer_en=1 cycle, the timer decrements and steps_out increments. Cycles with timer_en=0 hold all state; spikes are ignored on those cycles.
- Mode 0 (first-spike):
  - On the first timer_en cycle with any spikes_in bit set, the winner is the lowest-index asserted neuron. class_out takes that neuron's class, timeout=0, and the state goes to DONE.
  - If the timer reaches 0 with no spike: class_out=N_CLASS, timeout=1, go to DONE.
  - A spike on the final step wins over timeout (timeout=0).
- Mode 1 (vote):
  - On each timer_en cycle, each class counter adds the popcount of its asserted neurons. Counters saturate at 2^CNT_W-1.
  - The decision is made on the step that takes the timer to 0, and includes that step's spikes.
  - class_out = argmax of the counters; ties resolve to the lowest class index.
  - All counters zero gives class_out=N_CLASS and timeout=1.
- Latency: decision on timer_en cycle t gives result_valid=1 at t+1.
- DONE:
  - class_out, timeout and steps_out are held stable while result_valid=1.
  - result_ack=1 returns the FSM to IDLE; result_valid drops the next cycle.
  - start is ignored in DONE and RUN, including start and ack asserted in the same cycle; start must be re-issued in IDLE.
- Outputs keep their last values in IDLE until the next start clears steps_out; class_out and timeout update only at a decision.
- Widths: counter add = CNT_W + $clog2(N_OUT+1) bits internally, then clamp. The step timer never underflows; it stops at 0.

Decomposition:
- Shared package snn_arb_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - MODE_FIRST=0 and MODE_VOTE=1 constants
  - function class_of(i) = i mod N_CLASS
  - function no_class(N_CLASS)
- One sub-module, class_argmax: combinational N_CLASS x CNT_W argmax with lowest-index tie-break and an all-zero flag. Used in mode 1 only.

Test Plan:
- Mode 0, defaults: start, then spikes_in=6'b010000 on step 3 -> one cycle later result_valid=1, class_out=1, timeout=0, steps_out=3; held until ack.
- Mode 0: spikes_in=6'b001100 on step 1 -> neuron 2 wins, class_out=2, steps_out=1.
- Mode 0, DURATION=300, no spikes -> after 300 timer_en pulses, class_out=3, timeout=1, steps_out=300. With a spike on step 300 instead -> timeout=0 with the spiking class.
- Mode 1, DURATION=4: four steps of 6'b001001 -> counter[0]=8, class 0. Repeat with class 0 and class 1 each totalling 3 -> tie, class_out=0.
- Mode 1, CNT_W=2, DURATION=10, neuron 1 spiking every step -> counter[1] saturates at 3, class_out=1.
- resetn=0 mid-RUN -> next cycle IDLE, result_valid=0, class_out=3. start during RUN/DONE ignored; start plus ack in DONE -> IDLE, busy=0.

Source files
------------

// File: rtl/spike_class_arbiter_pkg.sv
// snn_arb_pkg: shared FSM states, decision-mode codes and class mapping helpers.
package snn_arb_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int MODE_FIRST = 0;
  localparam int MODE_VOTE = 1;
  function automatic int class_of(input int i, input int n_class);
    return i % n_class;
  endfunction
  function automatic int no_class(input int n_class);
    return n_class;
  endfunction
endpackage

// File: rtl/spike_class_arbiter_if.sv
// spike_class_arbiter_if: inference handshake and result bus between controller and arbiter.
interface spike_class_arbiter_if #(
  parameter int N_OUT = 6,
  parameter int CLS_W = 2,
  parameter int TMR_W = 9
);
  logic start;
  logic timer_en;
  logic [N_OUT-1:0] spikes_in;
  logic result_ack;
  logic busy;
  logic result_valid;
  logic [CLS_W-1:0] class_out;
  logic timeout;
  logic [TMR_W-1:0] steps_out;
  modport master (
    output start, timer_en, spikes_in, result_ack,
    input busy, result_valid, class_out, timeout, steps_out
  );
  modport slave (
    input start, timer_en, spikes_in, result_ack,
    output busy, result_valid, class_out, timeout, steps_out
  );
endinterface

// File: rtl/spike_class_arbiter_argmax.sv
// class_argmax: index of the largest class counter, lowest index on ties, plus all-zero flag.
module class_argmax #(
  parameter int N_CLASS = 3,
  parameter int CNT_W = 8,
  parameter int IDX_W = 2
) (
  input  logic [N_CLASS-1:0][CNT_W-1:0] cnt,
  output logic [IDX_W-1:0] idx,
  output logic all_zero
);
  logic [CNT_W-1:0] best;
  always_comb begin
    idx = '0;
    best = cnt[0];
    for (int c = 1; c < N_CLASS; c++)
      if (cnt[c] > best) begin
        best = cnt[c];
        idx = IDX_W'(c);
      end
    all_zero = (best == '0);
  end
endmodule

// File: rtl/spike_class_arbiter.sv
// spike_class_arbiter: turns output-neuron spikes over an inference window into one class decision,
// either first-spike or spike-count vote, behind a start/valid/ack handshake.
module spike_class_arbiter
  import snn_arb_pkg::*;
#(
  parameter int N_OUT = 6,
  parameter int N_CLASS = 3,
  parameter int DURATION = 300,
  parameter int MODE = 0,
  parameter int CNT_W = 8,
  localparam int CLS_W = $clog2(N_CLASS + 1),
  localparam int TMR_W = $clog2(DURATION + 1)
) (
  input logic clk,
  input logic resetn,
  spike_class_arbiter_if.slave bus
);
  localparam int SUM_W = CNT_W + $clog2(N_OUT + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CLS_W-1:0] NONE = CLS_W'(no_class(N_CLASS));
  state_e state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d, steps_q, steps_d;
  logic [CLS_W-1:0] cls_q, cls_d, first_cls, am_idx;
  logic to_q, to_d, busy_q, valid_q, am_zero;
  logic [N_CLASS-1:0][CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic [SUM_W-1:0] sum;
  always_comb begin
    first_cls = '0;
    for (int i = N_OUT - 1; i >= 0; i--)
      if (bus.spikes_in[i]) first_cls = CLS_W'(class_of(i, N_CLASS));
  end
  // Counters accumulate in a wider sum so a full step of spikes cannot wrap before the clamp.
  always_comb begin
    cnt_nx = cnt_q;
    sum = '0;
    for (int c = 0; c < N_CLASS; c++) begin
      sum = SUM_W'(cnt_q[c]);
      for (int i = 0; i < N_OUT; i++)
        sum = sum + SUM_W'(bus.spikes_in[i] && class_of(i, N_CLASS) == c);
      cnt_nx[c] = (sum > SUM_W'(CMAX)) ? CMAX : sum[CNT_W-1:0];
    end
  end
  class_argmax #(.N_CLASS(N_CLASS), .CNT_W(CNT_W), .IDX_W(CLS_W)) u_argmax (
    .cnt(cnt_nx),
    .idx(am_idx),
    .all_zero(am_zero)
  );
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q;
    steps_d = steps_q;
    cls_d = cls_q;
    to_d = to_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE:
        if (bus.start) begin
          state_d = RUN;
          tmr_d = TMR_W'(DURATION);
          steps_d = '0;
          cnt_d = '0;
        end
      RUN:
        if (bus.timer_en) begin
          tmr_d = (tmr_q == '0) ? '0 : tmr_q - TMR_W'(1);
          steps_d = steps_q + TMR_W'(1);
          if (MODE == MODE_VOTE) begin
            cnt_d = cnt_nx;
            if (tmr_d == '0) begin
              state_d = DONE;
              cls_d = am_zero ? NONE : am_idx;
              to_d = am_zero;
            end
          end else if (|bus.spikes_in) begin
            state_d = DONE;
            cls_d = first_cls;
            to_d = 1'b0;
          end else if (tmr_d == '0) begin
            state_d = DONE;
            cls_d = NONE;
            to_d = 1'b1;
          end
        end
      DONE: state_d = bus.result_ack ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      tmr_q <= '0;
      steps_q <= '0;
      cls_q <= NONE;
      to_q <= 1'b0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      steps_q <= steps_d;
      cls_q <= cls_d;
      to_q <= to_d;
      cnt_q <= cnt_d;
      busy_q <= (state_d == RUN);
      valid_q <= (state_d == DONE);
    end
  end
  assign bus.busy = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.class_out = cls_q;
  assign bus.timeout = to_q;
  assign bus.steps_out = steps_q;
endmodule
